sysfun_sweep: RTL and testbench

Sequential stimulus/collector for the dimension-query cosim table. The table is a combinational block: a 128-bit input whose low 5 bits select a query, and a 128-bit output.
- sysfun_sweep drives every selector code into the table's input in turn.
- It registers each 128-bit response and serializes it as 32-bit beats over a valid/ready stream.
- It keeps a running 32-bit signature so a simulator run and an SV-symbolic run can be compared with a single word.

---
 rtl/sysfun_sweep_pkg.sv | 28 ++
 rtl/sysfun_sweep_ser.sv | 77 +++++++
 rtl/sysfun_sweep.sv | 125 ++++++++++++
 tb/tb_sysfun_sweep.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysfun_sweep_pkg.sv
// -----------------------------------------------------------------------------
// sysfun_sweep_pkg
// Shared definitions for the dimension-query table sweeper:
//   - default widths used by the top level and the serializer
//   - sweep FSM state encoding
//   - rotl1(): 1-bit left rotate used to fold beats into the signature
// -----------------------------------------------------------------------------
package sysfun_sweep_pkg;

  localparam int DEF_NUM_SEL = 32;
  localparam int DEF_SEL_W   = 5;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_BEAT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Rotation is defined at the default beat width; the signature is a
  // single 32-bit word so simulator and symbolic runs compare directly.
  function automatic logic [DEF_BEAT_W-1:0] rotl1(input logic [DEF_BEAT_W-1:0] v);
    return {v[DEF_BEAT_W-2:0], v[DEF_BEAT_W-1]};
  endfunction

endpackage

// File: rtl/sysfun_sweep_ser.sv
// -----------------------------------------------------------------------------
// sysfun_sweep_ser
// Captures one DATA_W-bit table response and presents it as DATA_W/BEAT_W
// beats, most significant word first, over a valid/ready stream.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        capture resp_in and rewind to the first word
//   resp_in     table response to capture
//   active      present beats (valid) while high
//   ready       consumer ready
//   valid       beat valid
//   data        current beat (zero when not active)
//   accept      valid && ready this cycle
//   last_word   current word is the final word of the response
// -----------------------------------------------------------------------------
module sysfun_sweep_ser
  import sysfun_sweep_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEAT_W = DEF_BEAT_W,
  localparam int NWORDS = DATA_W / BEAT_W,
  localparam int W_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] resp_in,
  input  logic              active,
  input  logic              ready,
  output logic              valid,
  output logic [BEAT_W-1:0] data,
  output logic              accept,
  output logic              last_word
);

  logic [DATA_W-1:0] resp_q, resp_d;
  logic [W_W-1:0]    w_q, w_d;
  logic [BEAT_W-1:0] words [NWORDS];

  // Word 0 is the most significant slice so beats leave MSB word first.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      words[i] = resp_q[DATA_W-1-i*BEAT_W -: BEAT_W];
    end
  end

  always_comb begin
    valid     = active;
    accept    = active && ready;
    last_word = (w_q == W_W'(NWORDS - 1));
    data      = active ? words[w_q] : '0;
  end

  // The word index only moves on an accepted beat, which is what keeps data
  // stable under backpressure; it wraps to zero after the final word.
  always_comb begin
    resp_d = resp_q;
    w_d    = w_q;
    if (load) begin
      resp_d = resp_in;
      w_d    = '0;
    end else if (accept) begin
      w_d = last_word ? '0 : w_q + W_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
      w_q    <= '0;
    end else begin
      resp_q <= resp_d;
      w_q    <= w_d;
    end
  end

endmodule

// File: rtl/sysfun_sweep.sv
// -----------------------------------------------------------------------------
// sysfun_sweep
// Sweeps every selector code 0..NUM_SEL-1 into a combinational query table,
// serializes each response as BEAT_W-bit beats and folds every accepted beat
// into a running signature.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle pulse, begins a sweep when idle
//   busy        sweep in progress (query/send phases)
//   done        one-cycle pulse after the final beat is accepted
//   q_in        table input, {zeros, selector}
//   q_out       table output (sampled only in the query phase)
//   beat_valid, beat_ready, beat_data, beat_last   response beat stream
//   sig         running signature
// -----------------------------------------------------------------------------
module sysfun_sweep
  import sysfun_sweep_pkg::*;
#(
  parameter int NUM_SEL = DEF_NUM_SEL,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BEAT_W  = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] q_out,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [BEAT_W-1:0] beat_data,
  output logic              beat_last,
  output logic [BEAT_W-1:0] sig
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SEL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BEAT_W-1:0] sig_q, sig_d;
  logic             load;
  logic             active;
  logic             accept;
  logic             last_word;

  sysfun_sweep_ser #(
    .DATA_W (DATA_W),
    .BEAT_W (BEAT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .resp_in   (q_out),
    .active    (active),
    .ready     (beat_ready),
    .valid     (beat_valid),
    .data      (beat_data),
    .accept    (accept),
    .last_word (last_word)
  );

  always_comb begin
    load      = (state_q == ST_QUERY);
    active    = (state_q == ST_SEND);
    busy      = (state_q == ST_QUERY) || (state_q == ST_SEND);
    done      = (state_q == ST_FIN);
    beat_last = active && (sel_q == LAST_SEL) && last_word;
    q_in      = {{(DATA_W-SEL_W){1'b0}}, sel_q};
    sig       = sig_q;
  end

  // Sweep control: one query cycle per selector, then as many send cycles
  // as the consumer needs; the signature is cleared only by a new start.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sig_d   = sig_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = '0;
          sig_d   = '0;
          state_d = ST_QUERY;
        end
      end
      ST_QUERY: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          sig_d = rotl1(sig_q) ^ beat_data;
          if (last_word) begin
            if (sel_q == LAST_SEL) begin
              state_d = ST_FIN;
            end else begin
              sel_d   = sel_q + SEL_W'(1);
              state_d = ST_QUERY;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sig_q   <= sig_d;
    end
  end

endmodule

// File: tb/tb_sysfun_sweep.sv
// -----------------------------------------------------------------------------
// tb_sysfun_sweep
// Three sweeper instances with stub query tables:
//   dutA  NUM_SEL=1, fixed response {A,B,C,D}
//   dutB  NUM_SEL=3, response depends on selector
//   dutC  defaults, response either constant 1 or the selector itself
// -----------------------------------------------------------------------------
module tb_sysfun_sweep;

  logic clk;

  // Instance A signals
  logic         rstA, startA, readyA;
  logic         busyA, doneA, beatValidA, beatLastA;
  logic [127:0] qInA, qOutA;
  logic [31:0]  beatDataA, sigA;

  // Instance B signals
  logic         rstB, startB, readyB;
  logic         busyB, doneB, beatValidB, beatLastB;
  logic [127:0] qInB, qOutB;
  logic [31:0]  beatDataB, sigB;

  // Instance C signals
  logic         rstC, startC, readyC;
  logic         busyC, doneC, beatValidC, beatLastC;
  logic [127:0] qInC, qOutC;
  logic [31:0]  beatDataC, sigC;
  bit           modeC;

  int nCompared;
  int nMismatched;

  typedef struct {
    bit          start;
    bit          ready;
    bit          expValid;
    logic [31:0] expData;
    bit          expLast;
    bit          expBusy;
    bit          expDone;
    logic [31:0] expSig;
  } vecA_t;

  vecA_t tabA [19];

  assign qOutA = {32'hA, 32'hB, 32'hC, 32'hD};
  assign qOutB = {32'hB000_0000, 32'hB100_0000, 32'hB200_0000, 32'hB300_0000}
               | {4{27'b0, qInB[4:0]}};
  assign qOutC = modeC ? {123'b0, qInC[4:0]} : 128'h1;

  sysfun_sweep #(.NUM_SEL(1)) dutA (
    .clk(clk), .rst(rstA), .start(startA), .busy(busyA), .done(doneA),
    .q_in(qInA), .q_out(qOutA), .beat_valid(beatValidA), .beat_ready(readyA),
    .beat_data(beatDataA), .beat_last(beatLastA), .sig(sigA)
  );

  sysfun_sweep #(.NUM_SEL(3)) dutB (
    .clk(clk), .rst(rstB), .start(startB), .busy(busyB), .done(doneB),
    .q_in(qInB), .q_out(qOutB), .beat_valid(beatValidB), .beat_ready(readyB),
    .beat_data(beatDataB), .beat_last(beatLastB), .sig(sigB)
  );

  sysfun_sweep dutC (
    .clk(clk), .rst(rstC), .start(startC), .busy(busyC), .done(doneC),
    .q_in(qInC), .q_out(qOutC), .beat_valid(beatValidC), .beat_ready(readyC),
    .beat_data(beatDataC), .beat_last(beatLastC), .sig(sigC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check steps the counters here.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecA_t v);
    startA = v.start;
    readyA = v.ready;
  endtask

  // Expected beat w of selector s for instance C's stub table.
  function automatic logic [31:0] expWordC(input bit m, input int s, input int w);
    logic [127:0] r;
    r = m ? {123'b0, 5'(s)} : 128'h1;
    r = r >> (32 * (3 - w));
    return r[31:0];
  endfunction

  // Full sweep on instance C with a scoreboard; optionally resets mid-sweep.
  task automatic runC(input bit m, input bit toggle, input bit repulse,
                      input int abortSel, input int abortWord);
    int cyc, beats, dones, lasts, sel, word;
    bit finished, holdPending;
    logic [31:0] model, expData, heldData;
    cyc = 0; beats = 0; dones = 0; lasts = 0; sel = 0; word = 0;
    finished = 0; holdPending = 0; model = '0; heldData = '0;
    modeC = m;
    @(negedge clk);
    startC = 1'b1;
    readyC = 1'b1;
    @(negedge clk);
    startC = 1'b0;
    while (!finished && cyc < 2000) begin
      readyC = toggle ? ((cyc % 2) == 0) : 1'b1;
      startC = repulse && (cyc == 10 || cyc == 50);
      #1;
      if (cyc == 0) begin
        checkOutput("c_busy_rise", {127'b0, busyC}, 128'd1);
        checkOutput("c_sig_clear", {96'b0, sigC}, 128'd0);
      end
      if (holdPending) checkOutput("c_hold_data", {96'b0, beatDataC}, {96'b0, heldData});
      holdPending = 0;
      if (beatValidC) begin
        expData = expWordC(m, sel, word);
        checkOutput("c_beat_data", {96'b0, beatDataC}, {96'b0, expData});
        checkOutput("c_beat_last", {127'b0, beatLastC}, {127'b0, (sel == 31 && word == 3)});
        if (word == 0) checkOutput("c_q_in", qInC, 128'(sel));
        if (sel == abortSel && word == abortWord) begin
          rstC = 1'b1;
          @(negedge clk);
          rstC = 1'b0;
          startC = 1'b0;
          #1;
          checkOutput("c_rst_busy", {127'b0, busyC}, 128'd0);
          checkOutput("c_rst_done", {127'b0, doneC}, 128'd0);
          checkOutput("c_rst_valid", {127'b0, beatValidC}, 128'd0);
          checkOutput("c_rst_data", {96'b0, beatDataC}, 128'd0);
          checkOutput("c_rst_last", {127'b0, beatLastC}, 128'd0);
          checkOutput("c_rst_sig", {96'b0, sigC}, 128'd0);
          checkOutput("c_rst_q_in", qInC, 128'd0);
          return;
        end
        if (readyC) begin
          model = {model[30:0], model[31]} ^ expData;
          beats++;
          if (beatLastC) lasts++;
          word++;
          if (word == 4) begin
            word = 0;
            sel++;
          end
        end else begin
          holdPending = 1;
          heldData = expData;
        end
      end
      if (doneC) begin
        dones++;
        finished = 1;
        checkOutput("c_busy_at_done", {127'b0, busyC}, 128'd0);
        checkOutput("c_sig_final", {96'b0, sigC}, {96'b0, model});
        if (!toggle) checkOutput("c_done_cycle", 128'(cyc), 128'd160);
      end
      @(negedge clk);
      cyc++;
    end
    startC = 1'b0;
    if (!finished) checkOutput("c_timeout", 128'd0, 128'd1);
    checkOutput("c_beats", 128'(beats), 128'd128);
    checkOutput("c_lasts", 128'(lasts), 128'd1);
    repeat (4) begin
      #1;
      if (doneC) dones++;
      @(negedge clk);
    end
    checkOutput("c_dones", 128'(dones), 128'd1);
    checkOutput("c_sig_hold", {96'b0, sigC}, {96'b0, model});
  endtask

  // NUM_SEL=3 with a 20-cycle stall on the very first beat.
  task automatic runB();
    int cnt, beats, dones, lasts;
    cnt = 0; beats = 0; dones = 0; lasts = 0;
    @(negedge clk);
    startB = 1'b1;
    readyB = 1'b0;
    @(negedge clk);
    startB = 1'b0;
    #1;
    while (!beatValidB && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    checkOutput("b_first_valid", {127'b0, beatValidB}, 128'd1);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("b_stall%0d", i), {96'b0, beatDataB}, {96'b0, 32'hB000_0000});
      checkOutput($sformatf("b_stall_sig%0d", i), {96'b0, sigB}, 128'd0);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    readyB = 1'b1;
    cnt = 0;
    while (dones == 0 && cnt < 200) begin
      #1;
      if (beatValidB && readyB) begin
        if (beats == 0) checkOutput("b_beat0", {96'b0, beatDataB}, {96'b0, 32'hB000_0000});
        beats++;
        if (beatLastB) begin
          lasts++;
          checkOutput("b_last_data", {96'b0, beatDataB}, {96'b0, 32'hB300_0002});
        end
      end
      if (doneB) dones++;
      @(negedge clk);
      cnt++;
    end
    checkOutput("b_beats", 128'(beats), 128'd12);
    checkOutput("b_lasts", 128'(lasts), 128'd1);
    checkOutput("b_dones", 128'(dones), 128'd1);
    checkOutput("b_q_in_last", qInB, 128'd2);
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    modeC = 1'b0;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    readyA = 1'b0; readyB = 1'b0; readyC = 1'b0;

    // start, ready | valid, data, last, busy, done, sig
    tabA[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    tabA[1]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tabA[2]  = '{1'b0, 1'b1, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0};
    tabA[3]  = '{1'b0, 1'b1, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA};
    tabA[4]  = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h1F};
    tabA[5]  = '{1'b0, 1'b1, 1'b1, 32'hD, 1'b1, 1'b1, 1'b0, 32'h32};
    tabA[6]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h69};
    tabA[7]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h69};
    tabA[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h69};
    tabA[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tabA[10] = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0};
    tabA[11] = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0};
    tabA[12] = '{1'b0, 1'b1, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0};
    tabA[13] = '{1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA};
    tabA[14] = '{1'b0, 1'b1, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA};
    tabA[15] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h1F};
    tabA[16] = '{1'b1, 1'b1, 1'b1, 32'hD, 1'b1, 1'b1, 1'b0, 32'h32};
    tabA[17] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h69};
    tabA[18] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h69};

    repeat (3) @(negedge clk);
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    #1;
    checkOutput("reset_c_sig", {96'b0, sigC}, 128'd0);
    checkOutput("reset_c_q_in", qInC, 128'd0);
    checkOutput("reset_c_valid", {127'b0, beatValidC}, 128'd0);
    @(negedge clk);

    $display("[TB] single-selector table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tabA[i]);
      #1;
      checkOutput($sformatf("a%0d_valid", i), {127'b0, beatValidA}, {127'b0, tabA[i].expValid});
      checkOutput($sformatf("a%0d_data", i), {96'b0, beatDataA}, {96'b0, tabA[i].expData});
      checkOutput($sformatf("a%0d_last", i), {127'b0, beatLastA}, {127'b0, tabA[i].expLast});
      checkOutput($sformatf("a%0d_busy", i), {127'b0, busyA}, {127'b0, tabA[i].expBusy});
      checkOutput($sformatf("a%0d_done", i), {127'b0, doneA}, {127'b0, tabA[i].expDone});
      checkOutput($sformatf("a%0d_sig", i), {96'b0, sigA}, {96'b0, tabA[i].expSig});
      checkOutput($sformatf("a%0d_q_in", i), qInA, 128'd0);
      @(negedge clk);
    end
    startA = 1'b0;

    $display("[TB] three-selector stall");
    runB();

    $display("[TB] constant-one sweep");
    runC(1'b0, 1'b0, 1'b0, -1, -1);

    $display("[TB] selector-echo sweep, toggling ready, start re-pulsed");
    runC(1'b1, 1'b1, 1'b1, -1, -1);

    $display("[TB] reset mid-sweep then restart");
    runC(1'b1, 1'b0, 1'b0, 7, 2);
    runC(1'b1, 1'b0, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
